// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared types and constants for the Pong match sequencer
package match_pkg;

    localparam int SCORE_W     = 7;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_WAIT,
        PLAY,
        POINT_WAIT,
        GAME_OVER
    } match_state_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                   input logic [SCORE_W-1:0] lim);
        return (v >= lim) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/frame_delay.sv
// rtl/frame_delay.sv - loadable frame-tick down-counter with a done pulse
module frame_delay
    import match_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [FRAME_CNT_W-1:0] i_value,
    input  logic                   i_en,
    input  logic                   i_tick,
    output logic                   o_done
);

    logic [FRAME_CNT_W-1:0] r_cnt;

    // Done fires on the tick that completes i_value frames, so load value-1.
    assign o_done = i_en && i_tick && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value - 8'd1;
        end else if (i_en && i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/match_ctl.sv
// rtl/match_ctl.sv - Pong match sequencer: serve timing, scoring, end of match
module match_ctl
    import match_pkg::*;
#(
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_DELAY = 60,
    parameter int POINT_DELAY = 90
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               miss_first,
    input  logic               miss_second,
    output logic               ball_freeze,
    output logic               ball_serve,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] points_first_player,
    output logic [SCORE_W-1:0] points_second_player,
    output logic               game_over,
    output logic               winner
);

    localparam logic [SCORE_W-1:0]     WIN   = SCORE_W'(WIN_SCORE);
    localparam logic [FRAME_CNT_W-1:0] SD_V  = FRAME_CNT_W'(SERVE_DELAY);
    localparam logic [FRAME_CNT_W-1:0] PD_V  = FRAME_CNT_W'(POINT_DELAY);

    match_state_t           r_state;
    logic [SCORE_W-1:0]     r_p1;
    logic [SCORE_W-1:0]     r_p2;
    logic                   r_dir;
    logic                   r_freeze;
    logic                   r_over;
    logic                   r_winner;

    logic                   w_load;
    logic [FRAME_CNT_W-1:0] w_load_val;
    logic                   w_en;
    logic                   w_done;
    logic [SCORE_W-1:0]     w_p1_inc;
    logic [SCORE_W-1:0]     w_p2_inc;

    assign w_p1_inc = sat_inc(r_p1, WIN);
    assign w_p2_inc = sat_inc(r_p2, WIN);
    assign w_en     = (r_state == SERVE_WAIT) || (r_state == POINT_WAIT);

    always_comb begin
        w_load     = 1'b0;
        w_load_val = SD_V;
        unique case (r_state)
            IDLE:       w_load = start;
            GAME_OVER:  w_load = start;
            POINT_WAIT: w_load = w_done;
            PLAY: begin
                w_load     = miss_first || miss_second;
                w_load_val = PD_V;
            end
            default:    w_load = 1'b0;
        endcase
    end

    frame_delay u_frame_delay (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (w_load_val),
        .i_en    (w_en),
        .i_tick  (frame_tick),
        .o_done  (w_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_p1     <= '0;
            r_p2     <= '0;
            r_dir    <= 1'b0;
            r_freeze <= 1'b1;
            r_over   <= 1'b0;
            r_winner <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_freeze <= 1'b1;
                    if (start) begin
                        r_dir   <= 1'b0;
                        r_state <= SERVE_WAIT;
                    end
                end
                SERVE_WAIT: begin
                    if (w_done) begin
                        r_freeze <= 1'b0;
                        r_state  <= PLAY;
                    end
                end
                PLAY: begin
                    if (miss_first && miss_second) begin
                        r_freeze <= 1'b1;
                        r_state  <= POINT_WAIT;
                    end else if (miss_first) begin
                        r_freeze <= 1'b1;
                        r_p2     <= w_p2_inc;
                        r_dir    <= 1'b0;
                        if (w_p2_inc == WIN) begin
                            r_over   <= 1'b1;
                            r_winner <= 1'b1;
                            r_state  <= GAME_OVER;
                        end else begin
                            r_state  <= POINT_WAIT;
                        end
                    end else if (miss_second) begin
                        r_freeze <= 1'b1;
                        r_p1     <= w_p1_inc;
                        r_dir    <= 1'b1;
                        if (w_p1_inc == WIN) begin
                            r_over   <= 1'b1;
                            r_winner <= 1'b0;
                            r_state  <= GAME_OVER;
                        end else begin
                            r_state  <= POINT_WAIT;
                        end
                    end
                end
                POINT_WAIT: begin
                    if (w_done) begin
                        r_state <= SERVE_WAIT;
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        r_p1     <= '0;
                        r_p2     <= '0;
                        r_over   <= 1'b0;
                        r_winner <= 1'b0;
                        r_dir    <= 1'b0;
                        r_state  <= SERVE_WAIT;
                    end
                end
                default: begin
                    r_freeze <= 1'b1;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    // Serve is decoded from the registered state so it coincides with the last tick.
    assign ball_serve           = (r_state == SERVE_WAIT) && w_done;
    assign ball_freeze          = r_freeze;
    assign serve_dir            = r_dir;
    assign points_first_player  = r_p1;
    assign points_second_player = r_p2;
    assign game_over            = r_over;
    assign winner               = r_winner;

endmodule
